// File: rtl/hw2_pipe_arb_if.sv
// Bundle between client logic, the round-robin scheduler and the external
// (a+/-b)*c datapath: two request channels, two response pulses, datapath I/O.
interface hw2_pipe_arb_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [7:0]       req0_a;
    logic [7:0]       req0_b;
    logic [7:0]       req0_c;
    logic             req0_s;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_a;
    logic [7:0]       req1_b;
    logic [7:0]       req1_c;
    logic             req1_s;
    logic             req1_ready;
    logic             rsp0_valid;
    logic [15:0]      rsp0_d;
    logic             rsp1_valid;
    logic [15:0]      rsp1_d;
    logic [7:0]       pipe_a;
    logic [7:0]       pipe_b;
    logic [7:0]       pipe_c;
    logic             pipe_s;
    logic [15:0]      pipe_d;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_c, req0_s,
        input  req1_valid, req1_a, req1_b, req1_c, req1_s,
        input  pipe_d,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_d, rsp1_valid, rsp1_d,
        output pipe_a, pipe_b, pipe_c, pipe_s,
        output gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_c, req0_s,
        output req1_valid, req1_a, req1_b, req1_c, req1_s,
        output pipe_d,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_d, rsp1_valid, rsp1_d,
        input  pipe_a, pipe_b, pipe_c, pipe_s,
        input  gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/hw2_pipe_arb.sv
// Two-client round-robin front end for a fixed-latency (a+/-b)*c datapath;
// a tag shift register steers each result back to the client that issued it.
module hw2_pipe_arb #(
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            reset,
    hw2_pipe_arb_if.slave   bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic              grant0_s;
    logic              grant1_s;
    logic              hs_s;
    logic              gnt_id_s;

    logic              prio_q,      prio_d;
    logic [7:0]        pipe_a_q,    pipe_a_d;
    logic [7:0]        pipe_b_q,    pipe_b_d;
    logic [7:0]        pipe_c_q,    pipe_c_d;
    logic              pipe_s_q,    pipe_s_d;
    logic [PIPE_LAT:0] tag_vld_q,   tag_vld_d;
    logic [PIPE_LAT:0] tag_id_q,    tag_id_d;
    logic              rsp0_vld_q,  rsp0_vld_d;
    logic              rsp1_vld_q,  rsp1_vld_d;
    logic [15:0]       rsp0_dat_q,  rsp0_dat_d;
    logic [15:0]       rsp1_dat_q,  rsp1_dat_d;
    logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
    logic [CNT_W-1:0]  cnt1_q,      cnt1_d;

    // Arbitration: a lone requester wins, a tie goes to the prio side; nothing is granted in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = ~prio_q;
            grant1_s = prio_q;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
    end

    assign hs_s     = grant0_s | grant1_s;
    assign gnt_id_s = grant1_s;

    // Next state: issue registers, tag shift, response routing and grant counters.
    always_comb begin
        prio_d     = prio_q;
        pipe_a_d   = pipe_a_q;
        pipe_b_d   = pipe_b_q;
        pipe_c_d   = pipe_c_q;
        pipe_s_d   = pipe_s_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        rsp0_vld_d = 1'b0;
        rsp1_vld_d = 1'b0;
        rsp0_dat_d = rsp0_dat_q;
        rsp1_dat_d = rsp1_dat_q;
        // Bubbles shift through too, so the last stage lines up with pipe_d.
        tag_vld_d  = {tag_vld_q[PIPE_LAT-1:0], hs_s};
        tag_id_d   = {tag_id_q[PIPE_LAT-1:0], gnt_id_s};

        if (hs_s) begin
            prio_d   = ~gnt_id_s;
            pipe_a_d = gnt_id_s ? bus.req1_a : bus.req0_a;
            pipe_b_d = gnt_id_s ? bus.req1_b : bus.req0_b;
            pipe_c_d = gnt_id_s ? bus.req1_c : bus.req0_c;
            pipe_s_d = gnt_id_s ? bus.req1_s : bus.req0_s;
        end else begin
            prio_d   = prio_q;
        end

        if (grant0_s) begin
            cnt0_d = sat_inc(cnt0_q);
        end else begin
            cnt0_d = cnt0_q;
        end

        if (grant1_s) begin
            cnt1_d = sat_inc(cnt1_q);
        end else begin
            cnt1_d = cnt1_q;
        end

        if (tag_vld_q[PIPE_LAT] && tag_id_q[PIPE_LAT]) begin
            rsp1_vld_d = 1'b1;
            rsp1_dat_d = bus.pipe_d;
        end else if (tag_vld_q[PIPE_LAT]) begin
            rsp0_vld_d = 1'b1;
            rsp0_dat_d = bus.pipe_d;
        end else begin
            rsp0_vld_d = 1'b0;
            rsp1_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset; clearing the tags drops in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            pipe_a_q   <= 8'h00;
            pipe_b_q   <= 8'h00;
            pipe_c_q   <= 8'h00;
            pipe_s_q   <= 1'b0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rsp0_dat_q <= 16'h0000;
            rsp1_dat_q <= 16'h0000;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            prio_q     <= prio_d;
            pipe_a_q   <= pipe_a_d;
            pipe_b_q   <= pipe_b_d;
            pipe_c_q   <= pipe_c_d;
            pipe_s_q   <= pipe_s_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            rsp0_vld_q <= rsp0_vld_d;
            rsp1_vld_q <= rsp1_vld_d;
            rsp0_dat_q <= rsp0_dat_d;
            rsp1_dat_q <= rsp1_dat_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.pipe_a     = pipe_a_q;
    assign bus.pipe_b     = pipe_b_q;
    assign bus.pipe_c     = pipe_c_q;
    assign bus.pipe_s     = pipe_s_q;
    assign bus.rsp0_valid = rsp0_vld_q;
    assign bus.rsp1_valid = rsp1_vld_q;
    assign bus.rsp0_d     = rsp0_dat_q;
    assign bus.rsp1_d     = rsp1_dat_q;
    assign bus.gnt_cnt0   = cnt0_q;
    assign bus.gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_hw2_pipe_arb.sv
// Bench for hw2_pipe_arb: a behavioural datapath behind the arbiter, a
// scoreboard of expected results/arrival cycles, and a table of grant vectors.
module tb_hw2_pipe_arb;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = 4;
    localparam int NVEC     = 14;

    typedef struct {
        logic        id;
        logic [15:0] d;
        int          due;
    } exp_t;

    typedef struct {
        logic       v0;
        logic [7:0] a0, b0, c0;
        logic       s0;
        logic       v1;
        logic [7:0] a1, b1, c1;
        logic       s1;
        logic       r0;
        logic       r1;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt [NVEC];
    logic [15:0] dp_q [PIPE_LAT];

    hw2_pipe_arb_if #(.CNT_W(CNT_W)) bus ();

    hw2_pipe_arb #(.PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] dp_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic s);
        logic [15:0] t;
        t = s ? ({8'h00, a} + {8'h00, b}) : ({8'h00, a} - {8'h00, b});
        return t * {8'h00, c};
    endfunction

    // External datapath: PIPE_LAT register stages after the registered pipe_* inputs.
    always @(posedge clk) begin
        dp_q[0] <= dp_model(bus.pipe_a, bus.pipe_b, bus.pipe_c, bus.pipe_s);
        for (int i = 1; i < PIPE_LAT; i++) dp_q[i] <= dp_q[i-1];
    end
    assign bus.pipe_d = dp_q[PIPE_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pop/compare responses, then push expectations for this cycle's handshakes.
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
        end else begin
            check("grant_mutex", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("rsp_both", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
                    check("rsp_id", 32'(bus.rsp1_valid), 32'(mon_e.id));
                    check("rsp_data", 32'(mon_e.id ? bus.rsp1_d : bus.rsp0_d), 32'(mon_e.d));
                    check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                end
            end
            if (bus.req0_valid && bus.req0_ready)
                sbq.push_back('{id: 1'b0, due: cyc + PIPE_LAT + 2,
                    d: dp_model(bus.req0_a, bus.req0_b, bus.req0_c, bus.req0_s)});
            if (bus.req1_valid && bus.req1_ready)
                sbq.push_back('{id: 1'b1, due: cyc + PIPE_LAT + 2,
                    d: dp_model(bus.req1_a, bus.req1_b, bus.req1_c, bus.req1_s)});
        end
    end

    task automatic set_req(input int r, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic s);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_s = s;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_s = s;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check(nm, 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        logic [NVEC-1:0] v0_pat;
        logic [NVEC-1:0] v1_pat;
        logic [NVEC-1:0] r0_pat;
        logic [NVEC-1:0] r1_pat;
        int exp0;
        int exp1;

        v0_pat = 14'b11101000111111;
        v1_pat = 14'b10101110111111;
        r0_pat = 14'b01001000010101;
        r1_pat = 14'b10100110101010;
        exp0 = 0;
        exp1 = 0;
        for (int i = 0; i < NVEC; i++) begin
            vt[i].v0 = v0_pat[i];
            vt[i].v1 = v1_pat[i];
            vt[i].r0 = r0_pat[i];
            vt[i].r1 = r1_pat[i];
            vt[i].a0 = 8'(i * 13 + 1);
            vt[i].b0 = 8'(i * 7 + 2);
            vt[i].c0 = 8'(i + 3);
            vt[i].s0 = i[0];
            vt[i].a1 = 8'(200 - i * 5);
            vt[i].b1 = 8'(i * 11 + 9);
            vt[i].c1 = 8'(i * 2 + 1);
            vt[i].s1 = ~i[1];
            exp0 += int'(r0_pat[i]);
            exp1 += int'(r1_pat[i]);
        end

        reset = 1'b1;
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) step();
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_pipe_a", 32'(bus.pipe_a), 32'd0);
        check("rst_pipe_b", 32'(bus.pipe_b), 32'd0);
        check("rst_pipe_c", 32'(bus.pipe_c), 32'd0);
        check("rst_pipe_s", 32'(bus.pipe_s), 32'd0);
        check("rst_rsp_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        check("rst_rsp0_d", 32'(bus.rsp0_d), 32'd0);
        check("rst_rsp1_d", 32'(bus.rsp1_d), 32'd0);
        check("rst_cnt0", 32'(bus.gnt_cnt0), 32'd0);
        check("rst_cnt1", 32'(bus.gnt_cnt1), 32'd0);

        // Single op from requester 0.
        step();
        set_req(0, 1'b1, 8'h10, 8'h05, 8'h03, 1'b1);
        @(negedge clk);
        check("single_rdy0", 32'(bus.req0_ready), 32'd1);
        check("single_rdy1", 32'(bus.req1_ready), 32'd0);
        step();
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("single_drain");
        check("single_rsp0_d", 32'(bus.rsp0_d), 32'h003F);

        // Subtract with wrap from requester 1.
        set_req(1, 1'b1, 8'h05, 8'h10, 8'h02, 1'b0);
        @(negedge clk);
        check("sub_rdy1", 32'(bus.req1_ready), 32'd1);
        step();
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("sub_drain");
        check("sub_rsp1_d", 32'(bus.rsp1_d), 32'hFFEA);
        check("sub_rsp0_hold", 32'(bus.rsp0_d), 32'h003F);

        // Contention and mixed traffic from a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            set_req(0, vt[i].v0, vt[i].a0, vt[i].b0, vt[i].c0, vt[i].s0);
            set_req(1, vt[i].v1, vt[i].a1, vt[i].b1, vt[i].c1, vt[i].s1);
            @(negedge clk);
            check($sformatf("vec%0d_rdy0", i), 32'(bus.req0_ready), 32'(vt[i].r0));
            check($sformatf("vec%0d_rdy1", i), 32'(bus.req1_ready), 32'(vt[i].r1));
            if (i == 6) begin
                check("contend_cnt0", 32'(bus.gnt_cnt0), 32'd3);
                check("contend_cnt1", 32'(bus.gnt_cnt1), 32'd3);
            end
            step();
        end
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("vec_drain");
        check("vec_cnt0", 32'(bus.gnt_cnt0), 32'(exp0));
        check("vec_cnt1", 32'(bus.gnt_cnt1), 32'(exp1));

        // Back-to-back single requester.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 8'hFF, 8'h01, (k == 3) ? 8'h01 : 8'h00, 1'b1);
            @(negedge clk);
            check($sformatf("b2b%0d_rdy0", k), 32'(bus.req0_ready), 32'd1);
            step();
        end
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("b2b_drain");
        check("b2b_last_d", 32'(bus.rsp0_d), 32'h0100);

        // Reset one cycle before the first response is due.
        set_req(0, 1'b1, 8'h21, 8'h02, 8'h04, 1'b1);
        @(negedge clk);
        step();
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b1, 8'h30, 8'h01, 8'h02, 1'b0);
        @(negedge clk);
        step();
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        step();
        reset = 1'b1;
        set_req(0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
        @(negedge clk);
        check("rst_mid_rdy0", 32'(bus.req0_ready), 32'd0);
        step();
        reset = 1'b0;
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("flush%0d_rsp", k), 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            step();
        end
        check("flush_pipe_a", 32'(bus.pipe_a), 32'd0);
        check("flush_pipe_b", 32'(bus.pipe_b), 32'd0);
        check("flush_pipe_c", 32'(bus.pipe_c), 32'd0);
        check("flush_pipe_s", 32'(bus.pipe_s), 32'd0);
        set_req(0, 1'b1, 8'h03, 8'h04, 8'h05, 1'b1);
        set_req(1, 1'b1, 8'h06, 8'h07, 8'h08, 1'b1);
        @(negedge clk);
        check("flush_prio_rdy0", 32'(bus.req0_ready), 32'd1);
        check("flush_prio_rdy1", 32'(bus.req1_ready), 32'd0);
        step();
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("flush_drain");

        // Counter saturation: 1 prior grant plus 20 more exceeds 4'hF.
        for (int k = 0; k < 20; k++) begin
            set_req(0, 1'b1, 8'(k), 8'(k + 3), 8'(2 * k + 1), k[0]);
            @(negedge clk);
            check($sformatf("sat%0d_rdy0", k), 32'(bus.req0_ready), 32'd1);
            step();
        end
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        drain("sat_drain");
        check("sat_cnt0", 32'(bus.gnt_cnt0), 32'hF);
        check("sat_cnt1", 32'(bus.gnt_cnt1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hw2_pipe_arb.md
Name: hw2_pipe_arb

Overview:
Two-requester round-robin scheduler that shares one pipelined (a±b)*c datapath (hw2_pipe, fixed latency PIPE_LAT).
- Accepts operand sets from two clients over valid/ready.
- Registers the winning set onto the datapath inputs.
- Tracks each in-flight op with a tag shift register.
- Routes each result back to its originating client, in order, as a one-cycle pulse.
- Sits between client logic and the hw2_pipe instance; the datapath itself is external.

Parameters:
PIPE_LAT, 3, cycles from pipe_* inputs changing (registered) to pipe_d valid; legal 1..8.
CNT_W, 16, width of per-requester grant counters.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operand set
req0_a  in  8  requester 0 operand a
req0_b  in  8  requester 0 operand b
req0_c  in  8  requester 0 operand c
req0_s  in  1  requester 0 select: 1=(a+b)*c, 0=(a-b)*c
req0_ready  out  1  requester 0 accepted this cycle
req1_valid, req1_a, req1_b, req1_c, req1_s, req1_ready  same as above, requester 1
rsp0_valid  out  1  one-cycle pulse: result for requester 0
rsp0_d  out  16  result for requester 0
rsp1_valid  out  1  one-cycle pulse: result for requester 1
rsp1_d  out  16  result for requester 1
pipe_a  out  8  registered operand a to datapath
pipe_b  out  8  registered operand b to datapath
pipe_c  out  8  registered operand c to datapath
pipe_s  out  1  registered select to datapath
pipe_d  in  16  datapath result
gnt_cnt0  out  CNT_W  saturating count of grants to requester 0
gnt_cnt1  out  CNT_W  saturating count of grants to requester 1

Behaviour:
- **Reset:** all outputs 0, the round-robin pointer prio=0 (requester 0 preferred), and all tag stages invalid. Reset applies on any clk edge with reset=1.
- **Reset mid-operation:** in-flight tags are cleared and their results are never reported. req*_ready=0 while reset=1.
- **Arbitration:** combinational, one grant max per cycle.
  - Only one valid: grant it.
  - Both valid: grant req[prio].
  - On a grant to i, prio<=~i next cycle. With no grant, prio holds.
- **Ready:** req_i_ready = grant_i. Handshake = valid & ready. Clients hold operands stable while valid & ~ready; the block does not check this.
- **Issue stage:** on a handshake at edge T, pipe_a/b/c/s <= the granted operands, visible from T+1. With no handshake, pipe_* hold their last value.
- **Tag pipe:** depth PIPE_LAT+1; each entry is {vld, id}.
  - Stage 0 <= {handshake, granted id}.
  - Each stage shifts every cycle, bubbles included.
  - The last stage aligns with pipe_d being valid for that op.
- **Response:** when the last stage is valid with id=i:
  - rsp_i_d <= pipe_d.
  - rsp_i_valid <= 1 for exactly one cycle; the other rsp_valid stays 0.
  - rsp_*_d holds its value when rsp_*_valid=0.
- **Latency:** handshake edge T -> rsp valid at T+PIPE_LAT+2. Throughput is 1 op/cycle. Responses return in grant order. No backpressure on responses.
- **Counters:** gnt_cnt_i increments on each handshake of requester i and saturates at all-ones.
- **Arithmetic:** performed in the datapath, 16-bit modulo; e.g. a-b<0 wraps. The arbiter passes data unmodified.

Test Plan:
1. **Single op:** reset 2 cycles, then req0 a=0x10 b=0x05 c=0x03 s=1 for one handshake -> req0_ready=1 the same cycle; rsp0_valid pulses once, 5 cycles later (PIPE_LAT=3), rsp0_d=0x003F; rsp1_valid stays 0.
2. **Subtract wrap:** req1 a=0x05 b=0x10 c=0x02 s=0 -> rsp1_d=0xFFEA.
3. **Contention:** both valid continuously for 6 cycles with distinct operands -> grants alternate 0,1,0,1,0,1 from reset; rsp pulses alternate in the same order on consecutive cycles; gnt_cnt0=gnt_cnt1=3.
4. **Back-to-back single requester:** req0 valid 4 cycles with c=0, then c=0x01 (a=0xFF b=0x01 s=1) -> ready every cycle; results 0,0,0,0x0100 on consecutive cycles.
5. **Reset mid-flight:** issue 2 ops, assert reset 1 cycle before the first rsp -> no rsp_valid pulses for either op; pipe_* =0 and prio=0 after reset.
6. **Saturation:** CNT_W=4, 20 grants to req0 -> gnt_cnt0=0xF.
